// File: rtl/axi_gp_reg_responder.sv
// AXI4 register-bank responder for one PS general-purpose master port.
// NREGS 32-bit RW registers; independent read and write engines accept
// FIXED and INCR bursts, one outstanding transaction per direction.
// Optional macro IRQ_STATUS_REG_EN turns reg[NREGS-1] into a W1C interrupt
// status register driving pl_ps_irq0; undefined, pl_ps_irq0 is tied low.
module axi_gp_reg_responder #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned ID_W   = 16,
  parameter int unsigned NREGS  = 16
) (
  input  logic              aclk,
  input  logic              areset,
  // Write address
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  // Write data
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  // Write response
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  // Read address
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  // Read data
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  // Interrupt
  input  logic [NREGS-1:0]  irq_set,
  output logic              pl_ps_irq0
);

  localparam int unsigned IdxW = $clog2(NREGS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREGS - 1);

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;

  wstate_e         wstate_q;
  logic            awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0] bid_q;
  logic [1:0]      bresp_q;
  logic [IdxW-1:0] widx_q;
  logic [7:0]      wlen_q, wcnt_q;
  logic            wfixed_q, werr_q;

  logic            aw_hs, w_hs, b_hs;
  logic            w_last_beat, w_beat_err;
  logic [IdxW-1:0] aw_idx;

  assign aw_hs       = s_axi_awvalid & awready_q;
  assign w_hs        = s_axi_wvalid & wready_q;
  assign b_hs        = bvalid_q & s_axi_bready;
  assign aw_idx      = s_axi_awaddr[2 +: IdxW];
  assign w_last_beat = (wcnt_q == wlen_q);
  // wlast must agree with the beat count; a mismatch poisons the response
  assign w_beat_err  = (s_axi_wlast != w_last_beat);

  // Write FSM: AW capture, data beats, then hold B until accepted
  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q  <= WIdle;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      unique case (wstate_q)
        WIdle: begin
          if (aw_hs) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s_axi_awid;
            widx_q    <= aw_idx;
            wlen_q    <= s_axi_awlen;
            wcnt_q    <= '0;
            wfixed_q  <= (s_axi_awburst == 2'b00);
            werr_q    <= 1'b0;
            wstate_q  <= WData;
          end
        end
        WData: begin
          if (w_hs) begin
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q | w_beat_err) ? 2'b10 : 2'b00;
              wstate_q <= WResp;
            end else begin
              wcnt_q <= wcnt_q + 8'd1;
              werr_q <= werr_q | w_beat_err;
              widx_q <= wfixed_q ? widx_q : widx_q + IdxW'(1);
            end
          end
        end
        WResp: begin
          if (b_hs) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= WIdle;
          end
        end
        default: wstate_q <= WIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];
  logic [31:0] wmask;

  // Expand byte strobes to a bit mask
  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{s_axi_wstrb[b]}};
    end
  end

`ifdef IRQ_STATUS_REG_EN
  localparam int unsigned NIrq = (NREGS < 32) ? NREGS : 32;

  logic [31:0] irq_set32;
  logic [31:0] irq_clr;
  logic        irq_q;

  // Only the low 32 set lines fit in the 32-bit status register
  always_comb begin
    irq_set32 = '0;
    for (int i = 0; i < int'(NIrq); i++) begin
      irq_set32[i] = irq_set[i];
    end
  end

  assign irq_clr = (w_hs && (widx_q == LastIdx)) ? (s_axi_wdata & wmask) : '0;
`endif

  // Next-state of each register: byte-merged AXI write, plus status update
  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) begin
      regs_d[i] = regs_q[i];
      if (w_hs && (widx_q == IdxW'(i))) begin
        regs_d[i] = (regs_q[i] & ~wmask) | (s_axi_wdata & wmask);
      end
    end
`ifdef IRQ_STATUS_REG_EN
    // Set wins over a same-cycle clear
    regs_d[NREGS-1] = (regs_q[NREGS-1] & ~irq_clr) | irq_set32;
`endif
  end

  // Register storage
  always_ff @(posedge aclk) begin
    for (int i = 0; i < int'(NREGS); i++) begin
      if (areset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef IRQ_STATUS_REG_EN
  // Interrupt follows the status register one cycle late
  always_ff @(posedge aclk) begin
    if (areset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |regs_q[NREGS-1];
    end
  end

  assign pl_ps_irq0 = irq_q;
`else
  logic unused_irq_set;
  assign unused_irq_set = ^irq_set;
  assign pl_ps_irq0     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  typedef enum logic {RIdle, RData} rstate_e;

  rstate_e         rstate_q;
  logic            arready_q, rvalid_q, rlast_q;
  logic [ID_W-1:0] rid_q;
  logic [31:0]     rdata_q;
  logic [IdxW-1:0] ridx_q;
  logic [7:0]      rlen_q, rcnt_q;
  logic            rfixed_q;

  logic            ar_hs, r_hs;
  logic [IdxW-1:0] ar_idx, r_next_idx;

  assign ar_hs      = s_axi_arvalid & arready_q;
  assign r_hs       = rvalid_q & s_axi_rready;
  assign ar_idx     = s_axi_araddr[2 +: IdxW];
  assign r_next_idx = rfixed_q ? ridx_q : ridx_q + IdxW'(1);

  // Read FSM: AR capture, then one registered beat per R handshake
  always_ff @(posedge aclk) begin
    if (areset) begin
      rstate_q  <= RIdle;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rfixed_q  <= 1'b0;
    end else begin
      unique case (rstate_q)
        RIdle: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= s_axi_arid;
            rdata_q   <= regs_q[ar_idx];
            rlast_q   <= (s_axi_arlen == 8'd0);
            ridx_q    <= ar_idx;
            rlen_q    <= s_axi_arlen;
            rcnt_q    <= '0;
            rfixed_q  <= (s_axi_arburst == 2'b00);
            rstate_q  <= RData;
          end
        end
        RData: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= RIdle;
            end else begin
              ridx_q  <= r_next_idx;
              rdata_q <= regs_q[r_next_idx];
              rcnt_q  <= rcnt_q + 8'd1;
              rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
            end
          end
        end
        default: rstate_q <= RIdle;
      endcase
    end
  end

  // Bits outside the register index only alias the bank
  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr[1:0], s_axi_awaddr[ADDR_W-1:2+IdxW],
                         s_axi_araddr[1:0], s_axi_araddr[ADDR_W-1:2+IdxW]};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi_gp_reg_responder.sv
// Randomized self-checking bench for axi_gp_reg_responder.
// A plain array models the register bank; bursts are expanded beat by beat.
module tb_axi_gp_reg_responder;

  localparam int unsigned ADDR_W = 40;
  localparam int unsigned ID_W   = 16;
  localparam int unsigned NREGS  = 16;

  logic              aclk = 1'b0;
  logic              areset;
  logic [ID_W-1:0]   s_axi_awid;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [7:0]        s_axi_awlen;
  logic [1:0]        s_axi_awburst;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wlast;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ID_W-1:0]   s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [NREGS-1:0]  irq_set;
  logic              pl_ps_irq0;

  always #5 aclk = ~aclk;

  axi_gp_reg_responder #(
    .ADDR_W(ADDR_W),
    .ID_W  (ID_W),
    .NREGS (NREGS)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .irq_set       (irq_set),
    .pl_ps_irq0    (pl_ps_irq0)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] model [NREGS];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [31:0] rd_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic int start_idx(input logic [ADDR_W-1:0] a);
    return int'((a >> 2) % NREGS);
  endfunction

  function automatic void model_write_beat(input int idx, input logic [31:0] d,
                                           input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
`ifdef IRQ_STATUS_REG_EN
        if (idx == int'(NREGS) - 1) model[idx][8*b +: 8] = model[idx][8*b +: 8] & ~d[8*b +: 8];
        else
`endif
        model[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
  endfunction

  // Full write burst using wq_data/wq_strb; err_beat < 0 means wlast is correct
  task automatic axi_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input int len, input logic [1:0] burst, input int err_beat,
                           input bit gaps);
    int idx;
    int n;
    bit err;
    idx = start_idx(addr);
    err = 1'b0;
    s_axi_awid    = id;
    s_axi_awaddr  = addr;
    s_axi_awlen   = 8'(len);
    s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 200) begin tick(); n++; end
    check_eq("awready", s_axi_awready, 1);
    tick();
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      s_axi_wdata  = wq_data[b];
      s_axi_wstrb  = wq_strb[b];
      s_axi_wlast  = (b == len) ^ (b == err_beat);
      s_axi_wvalid = 1'b1;
      if (b == err_beat) err = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 200) begin tick(); n++; end
      check_eq("wready", s_axi_wready, 1);
      tick();
      s_axi_wvalid = 1'b0;
      model_write_beat(idx, wq_data[b], wq_strb[b]);
      if (burst != 2'b00) idx = (idx + 1) % int'(NREGS);
    end
    check_eq("bvalid_rise", s_axi_bvalid, 1);
    check_eq("wready_drop", s_axi_wready, 0);
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    check_eq("bvalid_hold", s_axi_bvalid, 1);
    check_eq("bid", s_axi_bid, id);
    check_eq("bresp", s_axi_bresp, err ? 2'b10 : 2'b00);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check_eq("bvalid_drop", s_axi_bvalid, 0);
    check_eq("awready_back", s_axi_awready, 1);
    wq_data.delete();
    wq_strb.delete();
  endtask

  // Full read burst, every beat compared against the model
  task automatic axi_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input int len, input logic [1:0] burst, input bit stalls);
    int idx;
    int n;
    idx = start_idx(addr);
    rd_q.delete();
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 200) begin tick(); n++; end
    check_eq("arready", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (!stalls && b > 0) check_eq("r_back_to_back", s_axi_rvalid, 1);
      n = 0;
      while (!s_axi_rvalid && n < 200) begin tick(); n++; end
      check_eq("rvalid", s_axi_rvalid, 1);
      if (stalls) begin
        s_axi_rready = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          tick();
          check_eq("stall_rvalid", s_axi_rvalid, 1);
          check_eq("stall_rdata", s_axi_rdata, model[idx]);
          check_eq("stall_rid", s_axi_rid, id);
          check_eq("stall_rlast", s_axi_rlast, b == len);
        end
      end
      check_eq("rdata", s_axi_rdata, model[idx]);
      check_eq("rid", s_axi_rid, id);
      check_eq("rlast", s_axi_rlast, b == len);
      check_eq("rresp", s_axi_rresp, 2'b00);
      rd_q.push_back(s_axi_rdata);
      s_axi_rready = 1'b1;
      tick();
      if (stalls) s_axi_rready = 1'b0;
      if (burst != 2'b00) idx = (idx + 1) % int'(NREGS);
    end
    s_axi_rready = 1'b0;
    check_eq("rvalid_end", s_axi_rvalid, 0);
    check_eq("arready_back", s_axi_arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]       d [4];
    logic [63:0]       rnd;
    logic [31:0]       va, vb;
    int                len, err_beat;
    areset        = 1'b1;
    s_axi_awid    = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_arid    = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    irq_set       = '0;
    for (int i = 0; i < int'(NREGS); i++) model[i] = '0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_awready", s_axi_awready, 1);
    check_eq("rst_arready", s_axi_arready, 1);
    check_eq("rst_wready", s_axi_wready, 0);
    check_eq("rst_bvalid", s_axi_bvalid, 0);
    check_eq("rst_rvalid", s_axi_rvalid, 0);
    check_eq("rst_rlast", s_axi_rlast, 0);
    check_eq("rst_irq", pl_ps_irq0, 0);
    check_eq("rst_bid", s_axi_bid, 0);
    check_eq("rst_bresp", s_axi_bresp, 0);
    check_eq("rst_rid", s_axi_rid, 0);
    check_eq("rst_rdata", s_axi_rdata, 0);
    check_eq("rst_rresp", s_axi_rresp, 0);
    areset = 1'b0;
    tick();

    // Single write then read
    wq_data.push_back(32'hDEADBEEF); wq_strb.push_back(4'hF);
    axi_write(16'h1234, 40'h8, 0, 2'b01, -1, 1'b0);
    axi_read(16'h0042, 40'h8, 0, 2'b01, 1'b0);
    check_eq("single_data", rd_q[0], 32'hDEADBEEF);

    // INCR 4 beats from index NREGS-2 wraps to 0,1
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      wq_data.push_back(d[i]); wq_strb.push_back(4'hF);
    end
    axi_write(16'h0011, 40'((NREGS - 2) * 4), 3, 2'b01, -1, 1'b0);
    axi_read(16'h0022, 40'((NREGS - 2) * 4), 3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) check_eq("incr_wrap_data", rd_q[i], d[i]);
    axi_read(16'h0023, 40'h0, 0, 2'b01, 1'b0);
    check_eq("incr_wrap_reg0", rd_q[0], d[2]);

    // Byte strobes on a FIXED burst
    wq_data.push_back(32'h11223344); wq_strb.push_back(4'hF);
    axi_write(16'h0003, 40'hC, 0, 2'b01, -1, 1'b0);
    wq_data.push_back(32'hAAAAAAAA); wq_strb.push_back(4'h1);
    wq_data.push_back(32'hAAAAAAAA); wq_strb.push_back(4'h8);
    axi_write(16'h0004, 40'hC, 1, 2'b00, -1, 1'b0);
    axi_read(16'h0005, 40'hC, 0, 2'b01, 1'b0);
    check_eq("fixed_strobe", rd_q[0], 32'hAA2233AA);

    // Early wlast: SLVERR, both beats still written; read back under stalls
    wq_data.push_back(32'hC0DE0001); wq_strb.push_back(4'hF);
    wq_data.push_back(32'hC0DE0002); wq_strb.push_back(4'hF);
    axi_write(16'h0BAD, 40'h20, 1, 2'b01, 0, 1'b1);
    axi_read(16'h0BEE, 40'h20, 1, 2'b01, 1'b1);
    check_eq("err_beat0", rd_q[0], 32'hC0DE0001);
    check_eq("err_beat1", rd_q[1], 32'hC0DE0002);

    // Concurrent FIXED read and single write to reg 5
    va = 32'h5A5A0001;
    vb = 32'hB0B0B0B0;
    wq_data.push_back(va); wq_strb.push_back(4'hF);
    axi_write(16'h0001, 40'h14, 0, 2'b01, -1, 1'b0);
    s_axi_arid = 16'h0007; s_axi_araddr = 40'h14; s_axi_arlen = 8'd3; s_axi_arburst = 2'b00;
    s_axi_arvalid = 1'b1;
    s_axi_awid = 16'h0009; s_axi_awaddr = 40'h14; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_awvalid = 1'b0;
    check_eq("cc_rvalid", s_axi_rvalid, 1);
    check_eq("cc_beat0", s_axi_rdata, va);
    check_eq("cc_wready", s_axi_wready, 1);
    s_axi_wdata = vb; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_rready = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    check_eq("cc_beat1_old", s_axi_rdata, va);
    check_eq("cc_bvalid", s_axi_bvalid, 1);
    check_eq("cc_bid", s_axi_bid, 16'h0009);
    check_eq("cc_bresp", s_axi_bresp, 2'b00);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check_eq("cc_beat2_new", s_axi_rdata, vb);
    tick();
    check_eq("cc_beat3_new", s_axi_rdata, vb);
    check_eq("cc_rlast", s_axi_rlast, 1);
    tick();
    s_axi_rready = 1'b0;
    check_eq("cc_rvalid_end", s_axi_rvalid, 0);
    model[5] = vb;

    // Interrupt status behaviour
`ifdef IRQ_STATUS_REG_EN
    irq_set = 16'h0005;
    tick();
    irq_set = '0;
    model[NREGS-1] = model[NREGS-1] | 32'h5;
    tick();
    check_eq("irq_set", pl_ps_irq0, 1);
    axi_read(16'h0100, 40'((NREGS - 1) * 4), 0, 2'b01, 1'b0);
    check_eq("irq_status_5", rd_q[0], 32'h5);
    wq_data.push_back(32'h1); wq_strb.push_back(4'hF);
    axi_write(16'h0101, 40'((NREGS - 1) * 4), 0, 2'b01, -1, 1'b0);
    axi_read(16'h0102, 40'((NREGS - 1) * 4), 0, 2'b01, 1'b0);
    check_eq("irq_status_4", rd_q[0], 32'h4);
    check_eq("irq_still_set", pl_ps_irq0, 1);
    wq_data.push_back(32'h4); wq_strb.push_back(4'hF);
    axi_write(16'h0103, 40'((NREGS - 1) * 4), 0, 2'b01, -1, 1'b0);
    tick();
    check_eq("irq_cleared", pl_ps_irq0, 0);
`else
    irq_set = '1;
    tick();
    irq_set = '0;
    tick();
    check_eq("irq_disabled", pl_ps_irq0, 0);
    axi_read(16'h0100, 40'((NREGS - 1) * 4), 0, 2'b01, 1'b0);
`endif

    // Randomized bursts
    for (int t = 0; t < 60; t++) begin
      rnd = {$urandom, $urandom};
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= len; b++) begin
          wq_data.push_back($urandom);
          wq_strb.push_back(4'($urandom));
        end
        err_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
        axi_write(16'($urandom), rnd[ADDR_W-1:0], len, 2'($urandom), err_beat, 1'b1);
      end else begin
        axi_read(16'($urandom), rnd[ADDR_W-1:0], len, 2'($urandom), 1'($urandom));
      end
    end

    // 256-beat INCR burst wraps the bank repeatedly
    for (int b = 0; b < 256; b++) begin
      wq_data.push_back($urandom);
      wq_strb.push_back(4'hF);
    end
    axi_write(16'hFFFF, 40'h4, 255, 2'b01, -1, 1'b0);
    axi_read(16'hFFFE, 40'h4, 255, 2'b01, 1'b0);

    // Reset in the middle of a read burst
    s_axi_arid = 16'h0077; s_axi_araddr = 40'h0; s_axi_arlen = 8'd7; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    tick();
    tick();
    s_axi_rready = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check_eq("mid_rst_rvalid", s_axi_rvalid, 0);
    check_eq("mid_rst_arready", s_axi_arready, 1);
    check_eq("mid_rst_awready", s_axi_awready, 1);
    check_eq("mid_rst_rdata", s_axi_rdata, 0);
    for (int i = 0; i < int'(NREGS); i++) model[i] = '0;
    tick();
    check_eq("mid_rst_quiet", s_axi_rvalid, 0);
    axi_read(16'h0078, 40'h0, int'(NREGS) - 1, 2'b01, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_gp_reg_responder.md
Name: axi_gp_reg_responder

Overview:
- AXI4 responder (slave) in the PL, terminating one PS general-purpose master port (maxigp0/maxigp1).
- Provides a bank of NREGS 32-bit read/write registers, with independent read and write engines that accept FIXED and INCR bursts.
- Optionally drives the PL-to-PS interrupt line from an interrupt status register.
- Instantiated once per used maxigp port, clocked by the same clock that feeds the port's maxihpm*_fpd_aclk.

Parameters:
- ADDR_W, 40, AXI address width.
- ID_W, 16, AXI ID width (AWID/ARID/BID/RID).
- NREGS, 16, number of 32-bit registers; power of two, 2..256.

Ports:
- aclk  in  1  clock; all logic is on its rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axi_awid  in  ID_W  write ID.
- s_axi_awaddr  in  ADDR_W  write byte address.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_awburst  in  2  00 = FIXED; anything else is treated as INCR.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bid  out  ID_W  response ID.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_arid  in  ID_W  read ID.
- s_axi_araddr  in  ADDR_W  read byte address.
- s_axi_arlen  in  8  beats minus 1.
- s_axi_arburst  in  2  burst type, same encoding as AW.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rid  out  ID_W  read ID.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response; always 00.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- irq_set  in  NREGS  per-bit pulse that sets interrupt status; bit i sets status bit i.
- pl_ps_irq0  out  1  interrupt to the PS.

Behaviour:
- Register index = addr[2 +: log2(NREGS)]; address bits [1:0] and all bits above the index are ignored, so the bank aliases across the address space.
- Reset: all registers = 0; both engines idle; awready = arready = 1; wready, bvalid, rvalid, rlast, pl_ps_irq0 = 0; bid, bresp, rid, rdata, rresp = 0.
- Reset asserted mid-burst aborts the burst immediately, with no further beats or responses.
- Write engine, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready = 1. On AW handshake, capture id, index, len, burst; set beat count = 0; next cycle awready = 0, wready = 1.
  - W_DATA: each W handshake writes the bytes enabled by wstrb into reg[idx]. Index then advances: +1 modulo NREGS for INCR; unchanged for FIXED.
  - The beat with count == len ends the burst: wready drops and bvalid rises on the next cycle.
  - bresp = 10 (SLVERR) if any beat's wlast disagreed with count == len; otherwise 00. Data beats are still written when SLVERR is reported.
  - W_RESP: bvalid held with bid = captured id until bready, then return to W_IDLE. awready rises the cycle after the B handshake.
- Read engine, R_IDLE -> R_DATA:
  - R_IDLE: arready = 1. On AR handshake, capture id, index, len, burst. Next cycle: rvalid = 1, rdata = reg[idx], rlast = (len == 0).
  - R_DATA: on each R handshake, advance the index as in the write engine and register the next beat's data. Beats are back-to-back when rready is held high.
  - After the handshake of the beat with rlast = 1: rvalid = 0 and arready = 1 on the next cycle.
  - rdata, rid, rlast stay stable while rvalid = 1 and rready = 0.
- rdata is the register value sampled in the cycle the beat is loaded. A write landing in that same cycle is not visible until the next beat.
- Read and write engines are fully independent and may be active concurrently; at most one outstanding transaction per direction.
- A 256-beat INCR burst wraps the index modulo NREGS.

Optional Feature:
- Macro IRQ_STATUS_REG_EN.
- Defined: reg[NREGS-1] is the interrupt status register.
  - Bit i is set by irq_set[i].
  - Writing 1 with the byte enabled clears the bit (write-1-to-clear); a set and a clear in the same cycle leave the bit set.
  - pl_ps_irq0 is registered: it equals the OR of all status bits one cycle after they change.
- Undefined: reg[NREGS-1] is an ordinary RW register, irq_set is ignored, and pl_ps_irq0 is constant 0.

Test Plan:
- Single write then read: AW addr 0x8, len 0, wdata 0xDEADBEEF, wstrb 0xF, wlast 1 -> bresp 00 with matching bid. Read addr 0x8 -> rdata 0xDEADBEEF, rlast 1.
- INCR write, 4 beats from index NREGS-2 -> beats land in regs 14, 15, 0, 1 (NREGS = 16). 4-beat read from the same address returns the same data in order, rlast on beat 4 only.
- Byte strobes and FIXED burst: reg 3 = 0x11223344, then FIXED 2-beat write with wstrb 0x1 then 0x8 and data 0xAAAAAAAA -> reg 3 reads 0xAA2233AA.
- Protocol error and backpressure: len 1 with wlast on beat 1 -> bresp 10, both beats written. Read with rready toggling -> rdata/rid stable during stalls, no dropped or duplicated beats.
- Concurrency and reset: read burst and write burst to the same register simultaneously -> read beat loaded in the write cycle returns the old value. areset mid-read burst -> rvalid 0 next cycle, all registers 0.
- IRQ_STATUS_REG_EN defined: pulse irq_set = 0x0005 -> status reads 0x5 and pl_ps_irq0 = 1. Write 0x1 -> status 0x4. Write 0x4 -> pl_ps_irq0 = 0.
